rotate_load_ctrl: RTL

Upstream feeder for the 8-bit rotate-left register. It accepts bytes from a producer over a valid/ready handshake and buffers them in a small FIFO. For each byte it issues a one-cycle parallel-load pulse with the byte on the rotator's data input, then holds off for a programmed number of rotation cycles before loading the next byte. Optionally it checks the rotator's output against the expected rotated value.

---
 rtl/rot_pkg.sv | 27 ++
 rtl/rot_fifo.sv | 58 +++++
 rtl/rotate_load_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// ---------------------------------------------------------------------------
// rot_pkg
// Shared definitions for the rotate-left register feeder:
//   ROT_WIDTH   - default byte width of the rotator
//   rot_state_t - controller FSM states (IDLE, LOAD, ROTATE)
//   rotl()      - rotate a ROT_WIDTH value left by an arbitrary amount
// ---------------------------------------------------------------------------
package rot_pkg;

   localparam int ROT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ROTATE
   } rot_state_t;

   // Amounts of WIDTH or more wrap around. An amount of zero returns the
   // value unchanged, because the right shift by the full width yields zero.
   function automatic logic [ROT_WIDTH-1:0] rotl(input logic [ROT_WIDTH-1:0] value,
                                                 input int amount);
      int a;
      a = amount % ROT_WIDTH;
      return (value << a) | (value >> (ROT_WIDTH - a));
   endfunction

endpackage

// File: rtl/rot_fifo.sv
// ---------------------------------------------------------------------------
// rot_fifo
// Synchronous DEPTH x WIDTH FIFO. The read and write pointers carry one
// extra MSB, so full and empty can be told apart when the index bits match.
// The head entry is presented combinationally on pop_data.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   push, push_data    write one entry (ignored while full)
//   pop                advance past the head entry (ignored while empty)
//   pop_data           current head entry
//   full, empty        decoded from the registered pointers
// ---------------------------------------------------------------------------
module rot_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; a reset empties the FIFO by realigning both pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/rotate_load_ctrl.sv
// ---------------------------------------------------------------------------
// rotate_load_ctrl
// Feeds bytes from a valid/ready producer into an 8-bit rotate-left register.
// Each byte gets a one-cycle parallel-load pulse followed by ROT_CYCLES
// rotation cycles before the next byte is loaded.
// Optional feature macro: ROT_CTRL_CHECK_EN
//   When defined, the loaded byte is shadowed and, one cycle after done,
//   rot_q is compared against that byte rotated left by ROT_CYCLES mod WIDTH.
//   A mismatch sets the sticky err output.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, in_data   producer byte
//   in_ready            FIFO not full (decoded from registered pointers)
//   rot_q               rotator output, used only by the check
//   load, d_out         registered load pulse and data to the rotator
//   busy                FSM not in IDLE
//   done                one-cycle pulse in the last rotation cycle of a byte
//   rot_cnt             rotation edges counted for the current byte
//   err                 sticky check failure (ROT_CTRL_CHECK_EN only)
// ---------------------------------------------------------------------------
module rotate_load_ctrl
   import rot_pkg::*;
#(
   parameter int WIDTH      = ROT_WIDTH,
   parameter int DEPTH      = 4,
   parameter int ROT_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic [WIDTH-1:0] rot_q,
   output logic             load,
   output logic [WIDTH-1:0] d_out,
   output logic             busy,
   output logic             done,
   output logic [7:0]       rot_cnt
`ifdef ROT_CTRL_CHECK_EN
   ,
   output logic             err
`endif
);

   localparam logic [7:0] LAST_CNT = 8'(ROT_CYCLES - 1);

   rot_state_t       state;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [WIDTH-1:0] fifo_head;

   assign in_ready = !fifo_full;

   // A byte leaves the FIFO whenever the FSM is about to start a new load:
   // from IDLE, or at the end of the final rotation cycle (back-to-back).
   assign fifo_pop = !fifo_empty &&
                     ((state == IDLE) || ((state == ROTATE) && (rot_cnt == LAST_CNT)));

   rot_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid && in_ready),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Controller FSM. All outputs are registered here; done is raised one
   // edge early so that it is high during the cycle in which rot_cnt equals
   // ROT_CYCLES-1, i.e. the cycle ending with the last rotation edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         load    <= 1'b0;
         d_out   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rot_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (!fifo_empty) begin
                  d_out <= fifo_head;
                  load  <= 1'b1;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               load    <= 1'b0;
               rot_cnt <= '0;
               done    <= (ROT_CYCLES == 1);
               state   <= ROTATE;
            end
            ROTATE: begin
               rot_cnt <= rot_cnt + 8'd1;
               if (rot_cnt == LAST_CNT) begin
                  done <= 1'b0;
                  if (!fifo_empty) begin
                     d_out <= fifo_head;
                     load  <= 1'b1;
                     state <= LOAD;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  done <= ((rot_cnt + 8'd1) == LAST_CNT);
               end
            end
            default: begin
               load  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ROT_CTRL_CHECK_EN
   localparam int ROT_AMT = ROT_CYCLES % WIDTH;

   logic [WIDTH-1:0] shadow;
   logic             check_pend;
   logic [WIDTH-1:0] expect_q;

   assign expect_q = WIDTH'(rotl(ROT_WIDTH'(shadow), ROT_AMT));

   // The shadow copy is taken on the load edge rather than on the pop, so a
   // back-to-back pop of the next byte cannot overwrite it before the check
   // of the previous byte happens in the following LOAD cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow     <= '0;
         check_pend <= 1'b0;
         err        <= 1'b0;
      end else begin
         check_pend <= done;
         if (state == LOAD) shadow <= d_out;
         if (check_pend && (rot_q != expect_q)) err <= 1'b1;
      end
   end
`else
   logic unused_rot_q;
   assign unused_rot_q = ^rot_q;
`endif

endmodule
